clk_div_multi: RTL

Fabric-based, parametrised multi-channel clock-enable and divided-clock generator. Sits downstream of the board clock manager and derives several phase-aligned slower timebases from one system clock. Each channel has a runtime divide ratio, phase offset and enable. All channels realign together on reset or on a SYNC pulse, and a LOCKED flag reports that the outputs are stable.

---
 rtl/clk_div_multi.sv | 93 +++++++++
 1 files changed

// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel clock-enable and divided-clock generator.
// Every channel divides the system clock by a runtime ratio with a runtime
// starting phase. All channels realign together on RST or SYNC, and LOCKED
// reports that the outputs have run undisturbed for LOCK_DLY edges.
module clk_div_multi #(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 8,
  parameter int LOCK_DLY  = 16
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [CHANNELS*CNT_WIDTH-1:0]   DIV,
  input  logic [CHANNELS*CNT_WIDTH-1:0]   PHASE,
  input  logic [CHANNELS-1:0]             EN,
  input  logic                            SYNC,
  output logic [CHANNELS-1:0]             CE,
  output logic [CHANNELS-1:0]             CLK_OUT,
  output logic                            LOCKED
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH:0]   WIDE_ONE = (CNT_WIDTH+1)'(1);
  localparam logic [15:0]          LOCK_MAX = 16'(LOCK_DLY);

  // RST and SYNC behave identically: both reload every channel.
  logic load;
  assign load = RST | SYNC;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [CNT_WIDTH-1:0] div_in;
    logic [CNT_WIDTH-1:0] phase_in;
    logic [CNT_WIDTH-1:0] period_load;
    logic [CNT_WIDTH-1:0] phase_load;
    logic [CNT_WIDTH-1:0] period;
    logic [CNT_WIDTH-1:0] last;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic [CNT_WIDTH:0]   high_len;
    logic                 ce_q;
    logic                 clk_out_q;

    assign div_in   = DIV[i*CNT_WIDTH +: CNT_WIDTH];
    assign phase_in = PHASE[i*CNT_WIDTH +: CNT_WIDTH];

    // Clamp the loaded ratio to at least 1 and the phase into the period;
    // derive the wrapped counter and the ceil(P/2) high length one bit wider.
    always_comb begin
      period_load = (div_in == '0) ? CNT_ONE : div_in;
      phase_load  = (phase_in > (period_load - CNT_ONE)) ? (period_load - CNT_ONE) : phase_in;
      last        = period - CNT_ONE;
      cnt_next    = (cnt == last) ? '0 : (cnt + CNT_ONE);
      high_len    = ({1'b0, period} + WIDE_ONE) >> 1;
    end

    // Channel state: reload on a load edge, otherwise free-run the counter
    // and register the gated strobe and square wave from the next count.
    always_ff @(posedge CLK) begin
      if (load) begin
        period    <= period_load;
        cnt       <= phase_load;
        ce_q      <= 1'b0;
        clk_out_q <= 1'b0;
      end else begin
        cnt       <= cnt_next;
        ce_q      <= EN[i] && (cnt_next == last);
        clk_out_q <= EN[i] && ({1'b0, cnt_next} < high_len);
      end
    end

    assign CE[i]      = ce_q;
    assign CLK_OUT[i] = clk_out_q;
  end

  logic [15:0] lock_cnt;
  logic [15:0] lock_next;

  // Saturating count of non-load edges since the last load.
  always_comb begin
    lock_next = (lock_cnt == LOCK_MAX) ? LOCK_MAX : (lock_cnt + 16'd1);
  end

  // Lock tracker: cleared by any load, raised once the count saturates.
  always_ff @(posedge CLK) begin
    if (load) begin
      lock_cnt <= '0;
      LOCKED   <= 1'b0;
    end else begin
      lock_cnt <= lock_next;
      LOCKED   <= (lock_next == LOCK_MAX);
    end
  end

endmodule
